// File: rtl/ex_muldiv_unit_if.sv
// Operand/result bundle between the EX stage and the iterative multiply/divide unit.
// The EX stage drives operands and control; the unit returns busy/done and the HI/LO registers.
interface ex_muldiv_unit_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [2:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              flush;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: 32 shift-add or restoring-divide
// iterations on magnitudes, then a single sign fix-up cycle that writes HI/LO.
module ex_muldiv_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    ex_muldiv_unit_if.slave mdu
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   opnd_q, opnd_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                is_div_q, is_div_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic                div0_q, div0_d;
    logic                done_q, done_d;

    logic                op_signed;
    logic [DATA_W-1:0]   mag_a, mag_b;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W-1:0]   div_sub;
    logic                div_ge;

    assign op_signed = ~mdu.op[0];
    assign mag_a     = (op_signed && mdu.a[DATA_W-1]) ? -mdu.a : mdu.a;
    assign mag_b     = (op_signed && mdu.b[DATA_W-1]) ? -mdu.b : mdu.b;

    // Multiply: acc holds {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

    // Divide: acc[DATA_W-1:0] holds dividend bits feeding in MSB-first and collects the quotient.
    assign div_shift = {rem_q, acc_q[DATA_W-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_sub   = div_shift[DATA_W-1:0] - opnd_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mdu.start && !mdu.flush) begin
                    case (mdu.op)
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            is_div_d  = mdu.op[1];
                            neg_res_d = op_signed & (mdu.a[DATA_W-1] ^ mdu.b[DATA_W-1]);
                            neg_rem_d = op_signed & mdu.a[DATA_W-1];
                            div0_d    = mdu.op[1] && (mdu.b == '0);
                            acc_d     = {{DATA_W{1'b0}}, (mdu.op[1] ? mag_a : mag_b)};
                            opnd_d    = mdu.op[1] ? mag_b : mag_a;
                            rem_d     = '0;
                            cnt_d     = '0;
                            state_d   = S_CALC;
                        end
                        3'b100:  hi_d = mdu.a;
                        3'b101:  lo_d = mdu.a;
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                if (mdu.flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        rem_d                = div_ge ? div_sub : div_shift[DATA_W-1:0];
                        acc_d[DATA_W-1:0]    = {acc_q[DATA_W-2:0], div_ge};
                    end else begin
                        acc_d                = {mul_sum, acc_q[DATA_W-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                // A flush arriving in the fix-up cycle still cancels the write-back.
                if (!mdu.flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        // Divide by zero leaves quotient all-ones and remainder equal to a.
                        lo_d = div0_q ? '1 : (neg_res_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0]);
                        hi_d = neg_rem_q ? -rem_q : rem_q;
                    end else begin
                        {hi_d, lo_d} = neg_res_q ? -acc_q : acc_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            done_q    <= done_d;
        end
    end

    assign mdu.busy = (state_q != S_IDLE);
    assign mdu.done = done_q;
    assign mdu.hi   = hi_q;
    assign mdu.lo   = lo_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized and directed bench for ex_muldiv_unit against a plain-arithmetic HI/LO model.
module tb_ex_muldiv_unit;
    localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2, OP_DIVU = 3'd3;
    localparam logic [2:0] OP_MTHI = 3'd4, OP_MTLO = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_hi, exp_lo;

    ex_muldiv_unit_if #(.DATA_W(32)) mdu ();

    ex_muldiv_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mdu   (mdu)
    );

    always #5 clk = ~clk;

    // Architectural result of one op given the current HI/LO.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] h, output logic [31:0] l);
        longint sa, sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h = exp_hi;
        l = exp_lo;
        case (op)
            OP_MULT:  begin r = sa * sb; h = r[63:32]; l = r[31:0]; end
            OP_MULTU: begin r = {32'd0, a} * {32'd0, b}; h = r[63:32]; l = r[31:0]; end
            OP_DIV: begin
                if (b == 32'd0) begin l = 32'hFFFF_FFFF; h = a; end
                else begin r = sa / sb; l = r[31:0]; r = sa % sb; h = r[31:0]; end
            end
            OP_DIVU: begin
                if (b == 32'd0) begin l = 32'hFFFF_FFFF; h = a; end
                else begin l = a / b; h = a % b; end
            end
            OP_MTHI: h = a;
            OP_MTLO: l = a;
            default: ;
        endcase
    endtask

    // Presents one start pulse across a single rising edge; returns one half-cycle after it.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic fl);
        @(negedge clk);
        mdu.start = 1'b1; mdu.op = op; mdu.a = a; mdu.b = b; mdu.flush = fl;
        @(negedge clk);
        mdu.start = 1'b0; mdu.flush = 1'b0;
        mdu.op = 3'($urandom_range(0, 7)); mdu.a = $urandom; mdu.b = $urandom;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string name);
        logic [31:0] eh, el;
        int cyc, busy_cyc;
        model(op, a, b, eh, el);
        issue(op, a, b, 1'b0);
        cyc = 1;
        busy_cyc = 0;
        while (mdu.done !== 1'b1 && cyc < 40) begin
            if (mdu.busy === 1'b1) busy_cyc++;
            if (cyc == 20) begin
                vectors++;
                if (mdu.hi !== exp_hi || mdu.lo !== exp_lo) begin
                    miscompares++;
                    $display("FAIL %s hold_mid_calc: hi=%h lo=%h expected hi=%h lo=%h",
                             name, mdu.hi, mdu.lo, exp_hi, exp_lo);
                end
            end
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (cyc != 34) begin
            miscompares++;
            $display("FAIL %s latency: done seen at cycle %0d expected 34", name, cyc);
        end
        vectors++;
        if (busy_cyc != 33) begin
            miscompares++;
            $display("FAIL %s busy_len: %0d cycles expected 33", name, busy_cyc);
        end
        vectors++;
        if (mdu.hi !== eh || mdu.lo !== el) begin
            miscompares++;
            $display("FAIL %s result: hi=%h lo=%h expected hi=%h lo=%h", name, mdu.hi, mdu.lo, eh, el);
        end
        vectors++;
        if (mdu.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_at_done: busy=%b expected 0", name, mdu.busy);
        end
        exp_hi = eh;
        exp_lo = el;
        @(negedge clk);
        vectors++;
        if (mdu.done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done_pulse: done=%b expected 0", name, mdu.done);
        end
        $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h", name, op, a, b, mdu.hi, mdu.lo);
    endtask

    // Single-cycle op or no-op issued from IDLE; fl models a concurrent flush.
    task automatic run_short(input logic [2:0] op, input logic [31:0] a, input logic fl,
                             input string name);
        logic [31:0] eh, el;
        if (fl) begin eh = exp_hi; el = exp_lo; end
        else model(op, a, 32'd0, eh, el);
        issue(op, a, $urandom, fl);
        vectors++;
        if (mdu.hi !== eh || mdu.lo !== el || mdu.busy !== 1'b0 || mdu.done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: hi=%h lo=%h busy=%b done=%b expected hi=%h lo=%h busy=0 done=0",
                     name, mdu.hi, mdu.lo, mdu.busy, mdu.done, eh, el);
        end
        exp_hi = eh;
        exp_lo = el;
        $display("%s op=%0d a=%h flush=%b -> hi=%h lo=%h", name, op, a, fl, mdu.hi, mdu.lo);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        mdu.start = 1'b0; mdu.flush = 1'b0; mdu.op = 3'd0; mdu.a = '0; mdu.b = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if (mdu.busy !== 1'b0 || mdu.done !== 1'b0 || mdu.hi !== 32'd0 || mdu.lo !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h expected all 0",
                     mdu.busy, mdu.done, mdu.hi, mdu.lo);
        end
        rst_n = 1'b1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        run_short(OP_MTHI, $urandom | 32'h1, 1'b0, "preload_hi");
        run_short(OP_MTLO, $urandom | 32'h1, 1'b0, "preload_lo");
        issue(OP_MULT, $urandom, $urandom, 1'b0);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (mdu.busy !== 1'b0 || mdu.done !== 1'b0 || mdu.hi !== 32'd0 || mdu.lo !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid_calc: busy=%b done=%b hi=%h lo=%h expected all 0",
                     mdu.busy, mdu.done, mdu.hi, mdu.lo);
        end
        $display("reset_mid_calc -> busy=%b hi=%h lo=%h", mdu.busy, mdu.hi, mdu.lo);
        @(negedge clk);
        rst_n = 1'b1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        run_op(OP_MULT, $urandom, $urandom, "mult_after_reset");
    endtask

    task automatic test_directed;
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,        "mult_neg3x7");
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_op(OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_m1xm1");
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,        "div_neg7_2");
        run_op(OP_DIVU,  32'd100,       32'd0,        "divu_by_zero");
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd0,        "div_neg_by_zero");
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        run_short(OP_MTHI, 32'h1234_5678, 1'b0, "mthi");
        run_short(OP_MTLO, 32'h9ABC_DEF0, 1'b0, "mtlo");
    endtask

    task automatic test_idle_noeffect;
        run_short(3'd6,    $urandom, 1'b0, "undef_op6");
        run_short(3'd7,    $urandom, 1'b0, "undef_op7");
        run_short(OP_MTHI, $urandom, 1'b1, "mthi_with_flush");
        run_short(OP_MULT, $urandom, 1'b1, "mult_with_flush");
    endtask

    task automatic test_mt_while_busy;
        logic [31:0] a, b, eh, el;
        int cyc;
        a = $urandom;
        b = $urandom;
        model(OP_MULTU, a, b, eh, el);
        issue(OP_MULTU, a, b, 1'b0);
        repeat (4) @(negedge clk);
        mdu.start = 1'b1; mdu.op = OP_MTLO; mdu.a = ~exp_lo;
        @(negedge clk);
        mdu.start = 1'b0;
        vectors++;
        if (mdu.lo !== exp_lo || mdu.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mtlo_while_busy: lo=%h busy=%b expected lo=%h busy=1", mdu.lo, mdu.busy, exp_lo);
        end
        cyc = 6;
        while (mdu.done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (cyc != 34 || mdu.hi !== eh || mdu.lo !== el) begin
            miscompares++;
            $display("FAIL mtlo_while_busy_result: cycle=%0d hi=%h lo=%h expected cycle=34 hi=%h lo=%h",
                     cyc, mdu.hi, mdu.lo, eh, el);
        end
        exp_hi = eh;
        exp_lo = el;
        @(negedge clk);
        $display("mtlo_while_busy a=%h b=%h -> hi=%h lo=%h", a, b, mdu.hi, mdu.lo);
    endtask

    task automatic test_flush(input logic [2:0] op, input int flush_cyc, input string name);
        int done_seen;
        issue(op, $urandom, $urandom, 1'b0);
        repeat (flush_cyc - 1) @(negedge clk);
        mdu.flush = 1'b1;
        @(negedge clk);
        mdu.flush = 1'b0;
        vectors++;
        if (mdu.busy !== 1'b0 || mdu.done !== 1'b0 || mdu.hi !== exp_hi || mdu.lo !== exp_lo) begin
            miscompares++;
            $display("FAIL %s: busy=%b done=%b hi=%h lo=%h expected busy=0 done=0 hi=%h lo=%h",
                     name, mdu.busy, mdu.done, mdu.hi, mdu.lo, exp_hi, exp_lo);
        end
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (mdu.done === 1'b1) done_seen++;
        end
        vectors++;
        if (done_seen != 0 || mdu.hi !== exp_hi || mdu.lo !== exp_lo) begin
            miscompares++;
            $display("FAIL %s_after: done pulses=%0d hi=%h lo=%h expected 0 pulses hi=%h lo=%h",
                     name, done_seen, mdu.hi, mdu.lo, exp_hi, exp_lo);
        end
        $display("%s op=%0d flushed at cycle %0d -> hi=%h lo=%h", name, op, flush_cyc, mdu.hi, mdu.lo);
    endtask

    task automatic test_random;
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 16; i++) begin
            op = 3'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: a = 32'h8000_0000;
                2: b = 32'($urandom_range(1, 9));
                3: b = -32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op(op, a, b, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_idle_noeffect();
        test_mt_while_busy();
        test_flush(OP_MULT, 20, "flush_mult_calc");
        test_flush(OP_DIV,  33, "flush_div_fix");
        test_random();
        run_op(OP_DIVU, $urandom, $urandom, "back_to_back_1");
        run_op(OP_MULT, $urandom, $urandom, "back_to_back_2");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
